config_queue: RTL

Parametrised successor to the single-entry configuration register stage of the tensor core. It accepts packed GEMM configurations through a valid/ready handshake and checks each one for legality. Legal configurations are buffered in a DEPTH-entry FIFO; illegal ones are rejected with an error code. The head entry is released into an active register bank only while the compute engine is idle, so the host can queue several jobs ahead of the engine.

---
 rtl/config_queue_if.sv | 8 +
 rtl/config_queue.sv | 87 ++++++++
 2 files changed

// File: rtl/config_queue_if.sv
// config_queue_if: valid/ready configuration offer channel from host to queue.
interface config_queue_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [29:0] cfg_data;
  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/config_queue.sv
// config_queue: legality-checked GEMM configuration FIFO feeding an idle-gated active register bank.
module config_queue #(
  parameter int DEPTH     = 4,
  parameter int MAX_SHAPE = 7,
  parameter int CNT_W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  config_queue_if.slave            cfg,
  input  logic                     flush,
  input  logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [29:0]              act_cfg,
  output logic                     act_valid,
  output logic                     act_load,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_valid,
  output logic [3:0]               err_code,
  output logic [CNT_W-1:0]         reject_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [4:0] FP4  = 5'd1;
  localparam logic [4:0] FP8  = 5'd2;
  localparam logic [4:0] FP16 = 5'd3;
  localparam logic [4:0] FP32 = 5'd4;
  localparam logic [2:0] FP8E5M2 = 3'd0;
  localparam logic [2:0] FP8E4M3 = 3'd1;
  localparam logic [3:0] MAXS = 4'(MAX_SHAPE);
  localparam logic [29:0] ACT_RST = {4'd2, 4'd2, 4'd2, FP32, FP8E5M2, FP8, 1'b0, 4'd0};
  logic [29:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    type_ab, type_cd;
  logic [2:0]    type_ab_sub;
  logic [3:0]    shape_m, shape_n, shape_k, err;
  logic          full, accept, push, pop, reject;
  assign type_ab     = cfg.cfg_data[9:5];
  assign type_ab_sub = cfg.cfg_data[12:10];
  assign type_cd     = cfg.cfg_data[17:13];
  assign shape_m     = cfg.cfg_data[21:18];
  assign shape_n     = cfg.cfg_data[25:22];
  assign shape_k     = cfg.cfg_data[29:26];
  always_comb begin
    err[0] = !(type_ab == FP4 || type_ab == FP8 || type_ab == FP16);
    err[1] = !(type_cd == FP16 || type_cd == FP32);
    err[2] = shape_m > MAXS || shape_n > MAXS || shape_k > MAXS;
    err[3] = type_ab == FP8 && !(type_ab_sub == FP8E5M2 || type_ab_sub == FP8E4M3);
  end
  assign full          = level == LW'(DEPTH);
  assign out_valid     = level != '0;
  assign cfg.cfg_ready = !full && !flush;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign push          = accept && err == 4'd0;
  assign reject        = accept && err != 4'd0;
  assign pop           = out_valid && out_ready && !busy && !flush;
  // Storage needs no reset: level gates every read.
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= cfg.cfg_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      act_cfg    <= ACT_RST;
      act_valid  <= 1'b0;
      act_load   <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= 4'd0;
      reject_cnt <= '0;
    end else begin
      act_load  <= pop;
      err_valid <= reject;
      wr_ptr    <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr    <= flush ? '0 : rd_ptr + AW'(pop);
      level     <= flush ? '0 : level + LW'(push) - LW'(pop);
      if (pop) begin
        act_cfg   <= mem[rd_ptr];
        act_valid <= 1'b1;
      end
      if (reject) begin
        err_code   <= err;
        reject_cnt <= reject_cnt + CNT_W'(!(&reject_cnt));
      end
    end
  end
endmodule
